// File: rtl/ufo_protocol_pkg.sv
// UFO protocol shared definitions.
// Header layout, session table entry and filter FSM states.
package ufo_protocol_pkg;

    localparam int HDR_CNT_OFS  = 0;
    localparam int HDR_CNT_W    = 16;
    localparam int HDR_SEQ_OFS  = 16;
    localparam int HDR_SEQ_W    = 32;
    localparam int HDR_TYPE_OFS = 48;
    localparam int HDR_TYPE_W   = 8;

    localparam logic [7:0] MSG_ADD = 8'h41;
    localparam logic [7:0] MSG_END = 8'h45;
    localparam logic [7:0] MSG_SEQ = 8'h53;

    typedef struct packed {
        logic        open;
        logic [31:0] expected;
    } session_entry_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        DECIDE,
        FORWARD,
        DROP
    } ufo_filter_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ufo_session_table.sv
// Per-session state RAM.
// One write port, one registered read port.
module ufo_session_table #(
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [32:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [32:0]   wr_data
);

    logic [32:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ufo_session_filter.sv
// Per-session sequence filter for the UFO receive path.
// Forwards in-order packets, drops duplicates, reports gaps.
module ufo_session_filter
    import ufo_protocol_pkg::*;
#(
    parameter int UFO_DATA_WIDTH = 64,
    parameter int MAX_SESSIONS   = 512,
    parameter int DROP_ON_GAP    = 1,
    localparam int W  = UFO_DATA_WIDTH,
    localparam int EW = $clog2(W/8),
    localparam int CW = $clog2(MAX_SESSIONS)
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic [W-1:0]  ufo_in_data,
    input  logic          ufo_in_startofpacket,
    input  logic          ufo_in_endofpacket,
    input  logic [EW-1:0] ufo_in_empty,
    input  logic          ufo_in_valid,
    input  logic [CW-1:0] ufo_in_channel,
    output logic          ufo_in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_startofpacket,
    output logic          out_endofpacket,
    output logic [EW-1:0] out_empty,
    output logic          out_valid,
    output logic [CW-1:0] out_channel,
    input  logic          out_ready,
    output logic          gap_valid,
    output logic [CW-1:0] gap_channel,
    output logic [31:0]   gap_expected,
    output logic [31:0]   gap_received,
    output logic [31:0]   stat_dup_count,
    output logic [31:0]   stat_gap_count,
    output logic [31:0]   stat_err_count
);

    ufo_filter_state_e state, state_nx;

    logic [CW-1:0]  init_addr;
    logic [CW-1:0]  chan_q;
    logic [15:0]    cnt_q;
    logic [31:0]    seq_q;
    logic [7:0]     type_q;
    logic [32:0]    rd_raw;
    session_entry_t ent;
    session_entry_t wr_ent;
    logic [CW-1:0]  wr_addr;
    logic           rd_en, wr_en;
    logic           dup_inc, gap_inc, err_inc, gap_fire;
    logic [31:0]    diff;
    logic           is_add, is_end, is_seq;

    assign ent    = session_entry_t'(rd_raw);
    assign diff   = seq_q - ent.expected;
    assign is_add = (type_q == MSG_ADD);
    assign is_end = (type_q == MSG_END);
    assign is_seq = (type_q == MSG_SEQ);

    ufo_session_table #(
        .DEPTH(MAX_SESSIONS)
    ) u_table (
        .clk    (clk),
        .rd_en  (rd_en),
        .rd_addr(ufo_in_channel),
        .rd_data(rd_raw),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(33'(wr_ent))
    );

    always_comb begin
        state_nx          = state;
        ufo_in_ready      = 1'b0;
        out_data          = '0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        out_empty         = '0;
        out_valid         = 1'b0;
        out_channel       = '0;
        rd_en             = 1'b0;
        wr_en             = 1'b0;
        wr_addr           = chan_q;
        wr_ent            = '0;
        dup_inc           = 1'b0;
        gap_inc           = 1'b0;
        err_inc           = 1'b0;
        gap_fire          = 1'b0;
        unique case (state)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = init_addr;
                if (init_addr == CW'(MAX_SESSIONS-1))
                    state_nx = IDLE;
            end
            IDLE: begin
                ufo_in_ready = !(ufo_in_valid && ufo_in_startofpacket);
                if (ufo_in_valid && ufo_in_startofpacket) begin
                    rd_en    = 1'b1;
                    state_nx = LOOKUP;
                end else if (ufo_in_valid) begin
                    err_inc = 1'b1;
                end
            end
            LOOKUP: state_nx = DECIDE;
            DECIDE: begin
                state_nx = DROP;
                unique case (1'b1)
                    is_add: begin
                        wr_en  = 1'b1;
                        wr_ent = '{open: 1'b1, expected: seq_q};
                    end
                    is_end: begin
                        wr_en  = 1'b1;
                        wr_ent = '{open: 1'b0, expected: ent.expected};
                    end
                    is_seq: begin
                        if (!ent.open) begin
                            err_inc = 1'b1;
                        end else if (diff == 32'd0) begin
                            wr_en    = 1'b1;
                            wr_ent   = '{open: 1'b1,
                                         expected: ent.expected + 32'(cnt_q)};
                            state_nx = FORWARD;
                        end else if (diff[31]) begin
                            dup_inc = 1'b1;
                        end else begin
                            gap_inc  = 1'b1;
                            gap_fire = 1'b1;
                            if (DROP_ON_GAP == 0) begin
                                wr_en    = 1'b1;
                                wr_ent   = '{open: 1'b1,
                                             expected: seq_q + 32'(cnt_q)};
                                state_nx = FORWARD;
                            end
                        end
                    end
                    default: err_inc = 1'b1;
                endcase
            end
            FORWARD: begin
                out_data          = ufo_in_data;
                out_startofpacket = ufo_in_startofpacket;
                out_endofpacket   = ufo_in_endofpacket;
                out_empty         = ufo_in_empty;
                out_valid         = ufo_in_valid;
                out_channel       = chan_q;
                ufo_in_ready      = out_ready;
                if (ufo_in_valid && out_ready && ufo_in_endofpacket)
                    state_nx = IDLE;
            end
            DROP: begin
                ufo_in_ready = 1'b1;
                if (ufo_in_valid && ufo_in_endofpacket)
                    state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state          <= INIT;
            init_addr      <= '0;
            chan_q         <= '0;
            cnt_q          <= '0;
            seq_q          <= '0;
            type_q         <= '0;
            gap_valid      <= 1'b0;
            gap_channel    <= '0;
            gap_expected   <= '0;
            gap_received   <= '0;
            stat_dup_count <= '0;
            stat_gap_count <= '0;
            stat_err_count <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT)
                init_addr <= init_addr + CW'(1);
            if (rd_en) begin
                chan_q <= ufo_in_channel;
                cnt_q  <= ufo_in_data[W-1-HDR_CNT_OFS -: HDR_CNT_W];
                seq_q  <= ufo_in_data[W-1-HDR_SEQ_OFS -: HDR_SEQ_W];
                type_q <= ufo_in_data[W-1-HDR_TYPE_OFS -: HDR_TYPE_W];
            end
            gap_valid <= gap_fire;
            if (gap_fire) begin
                gap_channel  <= chan_q;
                gap_expected <= ent.expected;
                gap_received <= seq_q;
            end
            if (dup_inc)
                stat_dup_count <= sat_inc(stat_dup_count);
            if (gap_inc)
                stat_gap_count <= sat_inc(stat_gap_count);
            if (err_inc)
                stat_err_count <= sat_inc(stat_err_count);
        end
    end

endmodule

// File: tb/tb_ufo_session_filter.sv
// Directed bench for ufo_session_filter.
// Runs a drop-on-gap and a forward-on-gap instance in lockstep.
module tb_ufo_session_filter;

    localparam int W  = 64;
    localparam int EW = 3;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]  in_data = '0;
    logic          in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
    logic [EW-1:0] in_empty = '0;
    logic [CW-1:0] in_ch = '0;
    logic          out_ready = 1'b1;

    logic          rdy0, o0_sop, o0_eop, o0_valid, g0_valid;
    logic [W-1:0]  o0_data;
    logic [EW-1:0] o0_empty;
    logic [CW-1:0] o0_ch, g0_ch;
    logic [31:0]   g0_exp, g0_rcv, dup0, gap0, err0;

    logic          rdy1, o1_sop, o1_eop, o1_valid, g1_valid;
    logic [W-1:0]  o1_data;
    logic [EW-1:0] o1_empty;
    logic [CW-1:0] o1_ch, g1_ch;
    logic [31:0]   g1_exp, g1_rcv, dup1, gap1, err1;

    ufo_session_filter #(.DROP_ON_GAP(1)) u_drop (
        .clk(clk), .areset_n(areset_n),
        .ufo_in_data(in_data), .ufo_in_startofpacket(in_sop),
        .ufo_in_endofpacket(in_eop), .ufo_in_empty(in_empty),
        .ufo_in_valid(in_valid), .ufo_in_channel(in_ch),
        .ufo_in_ready(rdy0),
        .out_data(o0_data), .out_startofpacket(o0_sop),
        .out_endofpacket(o0_eop), .out_empty(o0_empty),
        .out_valid(o0_valid), .out_channel(o0_ch), .out_ready(out_ready),
        .gap_valid(g0_valid), .gap_channel(g0_ch),
        .gap_expected(g0_exp), .gap_received(g0_rcv),
        .stat_dup_count(dup0), .stat_gap_count(gap0), .stat_err_count(err0)
    );

    ufo_session_filter #(.DROP_ON_GAP(0)) u_fwd (
        .clk(clk), .areset_n(areset_n),
        .ufo_in_data(in_data), .ufo_in_startofpacket(in_sop),
        .ufo_in_endofpacket(in_eop), .ufo_in_empty(in_empty),
        .ufo_in_valid(in_valid), .ufo_in_channel(in_ch),
        .ufo_in_ready(rdy1),
        .out_data(o1_data), .out_startofpacket(o1_sop),
        .out_endofpacket(o1_eop), .out_empty(o1_empty),
        .out_valid(o1_valid), .out_channel(o1_ch), .out_ready(out_ready),
        .gap_valid(g1_valid), .gap_channel(g1_ch),
        .gap_expected(g1_exp), .gap_received(g1_rcv),
        .stat_dup_count(dup1), .stat_gap_count(gap1), .stat_err_count(err1)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int gaps0 = 0;
    int stall_leak = 0;
    logic [CW-1:0] gc_ch = '0;
    logic [31:0]   gc_exp = '0, gc_rcv = '0;

    logic [W-1:0] q0_data[$];
    logic [15:0]  q0_tag[$];
    int           q0_cyc[$];
    logic [W-1:0] q1_data[$];
    logic [W-1:0] ex_data[$];
    logic [15:0]  ex_tag[$];

    always @(posedge clk) begin
        if (o0_valid && out_ready) begin
            q0_data.push_back(o0_data);
            q0_tag.push_back(16'({o0_ch, o0_sop, o0_eop, o0_empty}));
            q0_cyc.push_back(cyc);
        end
        if (o1_valid && out_ready)
            q1_data.push_back(o1_data);
        if (g0_valid) begin
            gaps0  <= gaps0 + 1;
            gc_ch  <= g0_ch;
            gc_exp <= g0_exp;
            gc_rcv <= g0_rcv;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic count_init();
        int n = 0;
        bit done = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            done = rdy0;
        end
        chk("init_cycles", 64'(n), 64'd512);
    endtask

    task automatic send(input logic [CW-1:0] ch, input logic [7:0] ty,
                        input logic [31:0] seq, input logic [15:0] cnt,
                        input int nb, input int stall, output int sopc);
        logic [W-1:0]  d;
        logic [EW-1:0] e;
        sopc = 0;
        ex_data.delete();
        ex_tag.delete();
        q0_data.delete();
        q0_tag.delete();
        q0_cyc.delete();
        q1_data.delete();
        for (int b = 0; b < nb; b++) begin
            int n = 0;
            bit acc = 0;
            d = (b == 0) ? {cnt, seq, ty, 8'h00} : {32'hCAFE_0000 + b, seq};
            e = (b == nb-1 && b > 0) ? 3'd2 : 3'd0;
            ex_data.push_back(d);
            ex_tag.push_back(16'({ch, b == 0, b == nb-1, e}));
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_sop   = (b == 0);
            in_eop   = (b == nb-1);
            in_empty = e;
            in_ch    = ch;
            if (b == 0)
                sopc = cyc;
            if (stall != 0 && b == stall) begin
                out_ready = 1'b0;
                repeat (4) begin
                    #1;
                    if (rdy0 || o0_valid && out_ready)
                        stall_leak++;
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            while (!acc && n < 50) begin
                #1;
                acc = rdy0;
                @(posedge clk);
                n++;
                if (!acc)
                    @(negedge clk);
            end
            if (!acc) begin
                chk("handshake_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_fwd(input string tag, input int sopc);
        chk({tag, "_beats"}, 64'(q0_data.size()), 64'(ex_data.size()));
        if (q0_data.size() == ex_data.size()) begin
            for (int i = 0; i < ex_data.size(); i++) begin
                chk({tag, "_data"}, q0_data[i], ex_data[i]);
                chk({tag, "_tag"}, 64'(q0_tag[i]), 64'(ex_tag[i]));
            end
            if (q0_cyc.size() > 0)
                chk({tag, "_lat"}, 64'(q0_cyc[0] - sopc), 64'd3);
        end
    endtask

    initial begin
        int s;
        int g;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(rdy0), 64'd0);
        chk("rst_out_valid", 64'(o0_valid), 64'd0);
        @(negedge clk);
        areset_n = 1'b1;
        count_init();
        chk("init_dup", 64'(dup0), 64'd0);
        chk("init_gap", 64'(gap0), 64'd0);
        chk("init_err", 64'(err0), 64'd0);

        send(9'd5, 8'h41, 32'd100, 16'd0, 1, 0, s);
        chk("add_dropped", 64'(q0_data.size()), 64'd0);
        send(9'd5, 8'h53, 32'd100, 16'd3, 3, 0, s);
        chk_fwd("seq100", s);
        send(9'd5, 8'h53, 32'd103, 16'd1, 1, 0, s);
        chk_fwd("seq103", s);

        send(9'd5, 8'h53, 32'd101, 16'd1, 2, 0, s);
        chk("dup_dropped", 64'(q0_data.size()), 64'd0);
        chk("dup_count", 64'(dup0), 64'd1);

        g = gaps0;
        send(9'd5, 8'h53, 32'd110, 16'd1, 2, 0, s);
        chk("gap_dropped", 64'(q0_data.size()), 64'd0);
        chk("gap_pulses", 64'(gaps0 - g), 64'd1);
        chk("gap_channel", 64'(gc_ch), 64'd5);
        chk("gap_expected", 64'(gc_exp), 64'd104);
        chk("gap_received", 64'(gc_rcv), 64'd110);
        chk("gap_count", 64'(gap0), 64'd1);
        chk("gap_fwd_beats", 64'(q1_data.size()), 64'd2);
        send(9'd5, 8'h53, 32'd111, 16'd1, 1, 0, s);
        chk("resync_fwd", 64'(q1_data.size()), 64'd1);
        chk("resync_fwd_gapcnt", 64'(gap1), 64'd1);
        chk("drop_second_gap", 64'(gap0), 64'd2);

        send(9'd7, 8'h41, 32'hFFFF_FFFF, 16'd0, 1, 0, s);
        send(9'd7, 8'h53, 32'hFFFF_FFFF, 16'd1, 1, 0, s);
        chk_fwd("wrap_max", s);
        send(9'd7, 8'h53, 32'd0, 16'd1, 2, 0, s);
        chk_fwd("wrap_zero", s);
        chk("wrap_no_gap", 64'(gap0), 64'd2);
        send(9'd7, 8'h45, 32'd0, 16'd0, 1, 0, s);
        send(9'd7, 8'h53, 32'd1, 16'd1, 1, 0, s);
        chk("closed_dropped", 64'(q0_data.size()), 64'd0);
        chk("closed_err", 64'(err0), 64'd1);
        send(9'd7, 8'h4A, 32'd1, 16'd1, 1, 0, s);
        chk("unknown_err", 64'(err0), 64'd2);

        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_eop   = 1'b1;
        #1;
        chk("stray_ready", 64'(rdy0), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_eop   = 1'b0;
        chk("stray_err", 64'(err0), 64'd3);

        send(9'd9, 8'h41, 32'd50, 16'd0, 1, 0, s);
        send(9'd9, 8'h53, 32'd50, 16'd4, 4, 2, s);
        chk_fwd("stall", s);
        chk("stall_leak", 64'(stall_leak), 64'd0);

        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_eop   = 1'b0;
        in_ch    = 9'd9;
        in_data  = {16'd2, 32'd54, 8'h53, 8'h00};
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 64'(o0_valid), 64'd1);
        areset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(o0_valid), 64'd0);
        chk("mid_rst_data", o0_data, 64'd0);
        chk("mid_rst_ready", 64'(rdy0), 64'd0);
        chk("mid_rst_dup", 64'(dup0), 64'd0);
        chk("mid_rst_err", 64'(err0), 64'd0);
        chk("mid_rst_gapcnt", 64'(gap0), 64'd0);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        count_init();
        send(9'd9, 8'h53, 32'd54, 16'd1, 1, 0, s);
        chk("post_rst_closed", 64'(q0_data.size()), 64'd0);
        chk("post_rst_err", 64'(err0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
